// File: rtl/hd_misr_pkg.sv
// hd_misr_pkg -- shared definitions for the result-compaction MISR block.
//   state_t      : run-control FSM states (IDLE, RUN, DONE)
//   word_t       : 32-bit result word / signature type
//   DEFAULT_POLY : default MISR feedback polynomial (CRC-32 style)
//   DEFAULT_SEED : default signature value loaded at the start of a run
package hd_misr_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam word_t DEFAULT_POLY = 32'h04C11DB7;
  localparam word_t DEFAULT_SEED = 32'hFFFFFFFF;

endpackage

// File: rtl/hd_misr_step.sv
// hd_misr_step -- one combinational MISR compaction step.
//   sig      in  : current signature
//   data     in  : result word being folded in
//   poly     in  : feedback polynomial
//   sig_next out : {sig[30:0],0} ^ (sig[31] ? poly : 0) ^ data
module hd_misr_step
  import hd_misr_pkg::*;
(
  input  word_t sig,
  input  word_t data,
  input  word_t poly,
  output word_t sig_next
);

  logic fb;
  assign fb = sig[31];

  // Bit 0 has no shifted-in predecessor; every other bit takes its neighbour.
  assign sig_next[0] = (fb & poly[0]) ^ data[0];

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_bit
      assign sig_next[gi] = sig[gi-1] ^ (fb & poly[gi]) ^ data[gi];
    end
  endgenerate

endmodule

// File: rtl/hd_result_misr.sv
// hd_result_misr -- compacts a run of 32-bit result words into a MISR signature.
//   clk, rst_n  : clock (rising edge) and asynchronous active-low reset
//   start       : begin a run (honoured in IDLE only), num_words sampled with it
//   in_valid/in_ready/in_data : word handshake, ready only while running
//   busy        : high while in RUN
//   done        : one-cycle pulse after the last word (or right after a 0-word start)
//   signature   : current MISR value
//   word_count  : words accepted in the current run
//   err_upper   : sticky flag, an accepted word had nonzero bits 31:16
// Optional feature: define HD_MISR_UPPER_CHECK_EN to build the upper-bit check;
// without it err_upper is tied low.
module hd_result_misr
  import hd_misr_pkg::*;
#(
  parameter word_t POLY = DEFAULT_POLY,
  parameter word_t SEED = DEFAULT_SEED
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] num_words,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] signature,
  output logic [15:0] word_count,
  output logic        err_upper
);

  state_t      state_reg;
  word_t       sig_reg;
  word_t       sig_next;
  logic [15:0] count_reg;
  logic [15:0] count_next;
  logic [15:0] target_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        accept;

  // busy_reg doubles as in_ready: the block only takes words while running.
  assign accept     = in_valid & busy_reg;
  assign count_next = count_reg + 16'd1;

  hd_misr_step u_step (
    .sig      (sig_reg),
    .data     (in_data),
    .poly     (POLY),
    .sig_next (sig_next)
  );

`ifdef HD_MISR_UPPER_CHECK_EN
  logic err_reg;
  assign err_upper = err_reg;
`else
  assign err_upper = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      sig_reg    <= '0;
      count_reg  <= '0;
      target_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
`ifdef HD_MISR_UPPER_CHECK_EN
      err_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            sig_reg    <= SEED;
            count_reg  <= '0;
            target_reg <= num_words;
`ifdef HD_MISR_UPPER_CHECK_EN
            err_reg    <= 1'b0;
`endif
            // An empty run skips RUN and reports completion straight away.
            if (num_words != 16'd0) begin
              state_reg <= ST_RUN;
              busy_reg  <= 1'b1;
            end else begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            sig_reg   <= sig_next;
            count_reg <= count_next;
`ifdef HD_MISR_UPPER_CHECK_EN
            if (in_data[31:16] != 16'd0) err_reg <= 1'b1;
`endif
            if (count_next == target_reg) begin
              state_reg <= ST_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = busy_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign signature  = sig_reg;
  assign word_count = count_reg;

endmodule
